data_matrix_ben_branch: RTL and testbench

//   Consumer side of the N/Z/P condition codes: the LC-3 branch-resolution unit.
//   On a BR instruction it samples reg_n/reg_z/reg_p against IR[11:9] and latches BEN.
//   It computes PC + SEXT(IR[8:0]) and issues a one-cycle ld_pc request to the PC mux.

---
 rtl/data_matrix_ben_branch_if.sv | 31 +++
 rtl/data_matrix_ben_branch.sv | 142 ++++++++++++++
 tb/tb_data_matrix_ben_branch.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_matrix_ben_branch_if.sv
// Branch-resolution unit bus: start/operands/flags in; BEN, PC target and status out.
interface data_matrix_ben_branch_if #(
    parameter int unsigned AW = 16
);
    logic          br_start;
    logic [AW-1:0] ir;
    logic [AW-1:0] pc;
    logic          reg_n;
    logic          reg_z;
    logic          reg_p;
    logic          br_busy;
    logic          br_done;
    logic          ben;
    logic          ld_pc;
    logic [AW-1:0] pc_target;
    logic          br_err;
    logic [15:0]   br_taken_cnt;
    logic [15:0]   br_total_cnt;

    // Control FSM / condition-code side
    modport master (
        output br_start, ir, pc, reg_n, reg_z, reg_p,
        input  br_busy, br_done, ben, ld_pc, pc_target, br_err, br_taken_cnt, br_total_cnt
    );

    // Branch-resolution unit side
    modport slave (
        input  br_start, ir, pc, reg_n, reg_z, reg_p,
        output br_busy, br_done, ben, ld_pc, pc_target, br_err, br_taken_cnt, br_total_cnt
    );
endinterface

// File: rtl/data_matrix_ben_branch.sv
// LC-3 branch-resolution unit: latches BEN from N/Z/P vs IR[11:9], computes
// PC + SEXT(PCoffset) and strobes ld_pc for one cycle when the branch is taken.
// Optional build macro: BR_STAT_EN enables saturating taken/total branch counters.
module data_matrix_ben_branch #(
    parameter int unsigned AW    = 16,
    parameter int unsigned OFF_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    data_matrix_ben_branch_if.slave  bus
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned CC_W  = 3;
    localparam int unsigned EXT_W = AW - OFF_W;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, EVAL, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CC_W-1:0]   cond_q,   cond_d;
    logic [OFF_W-1:0]  off_q,    off_d;
    logic [AW-1:0]     pc_q,     pc_d;
    logic              op_ok_q,  op_ok_d;
    logic              ben_q,    ben_d;
    logic [AW-1:0]     target_q, target_d;
    logic              done_q,   done_d;
    logic              ld_pc_q,  ld_pc_d;
    logic              err_q,    err_d;
    logic              busy_q,   busy_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cond_q   <= '0;
            off_q    <= '0;
            pc_q     <= '0;
            op_ok_q  <= 1'b0;
            ben_q    <= 1'b0;
            target_q <= '0;
            done_q   <= 1'b0;
            ld_pc_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cond_q   <= cond_d;
            off_q    <= off_d;
            pc_q     <= pc_d;
            op_ok_q  <= op_ok_d;
            ben_q    <= ben_d;
            target_q <= target_d;
            done_q   <= done_d;
            ld_pc_q  <= ld_pc_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // Next state; output values are computed one cycle ahead so they line up with the state
    always_comb begin
        state_d  = state_q;
        cond_d   = cond_q;
        off_d    = off_q;
        pc_d     = pc_q;
        op_ok_d  = op_ok_q;
        ben_d    = ben_q;
        target_d = target_q;
        done_d   = 1'b0;
        ld_pc_d  = 1'b0;
        err_d    = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.br_start) begin
                    cond_d  = bus.ir[OFF_W+CC_W-1:OFF_W];
                    off_d   = bus.ir[OFF_W-1:0];
                    pc_d    = bus.pc;
                    op_ok_d = (bus.ir[AW-1:AW-OP_W] == OP_W'(0));
                    err_d   = (bus.ir[AW-1:AW-OP_W] != OP_W'(0));
                    busy_d  = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                // Flags sampled a cycle after start so a same-cycle ld_cc is seen
                ben_d   = op_ok_q & (|(cond_q & {bus.reg_n, bus.reg_z, bus.reg_p}));
                err_d   = bus.br_start;
                busy_d  = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                target_d = pc_q + {{EXT_W{off_q[OFF_W-1]}}, off_q};
                err_d    = bus.br_start;
                busy_d   = 1'b1;
                done_d   = 1'b1;
                ld_pc_d  = ben_q;
                state_d  = DONE;
            end
            DONE: begin
                err_d   = bus.br_start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.br_busy   = busy_q;
    assign bus.br_done   = done_q;
    assign bus.ben       = ben_q;
    assign bus.ld_pc     = ld_pc_q;
    assign bus.pc_target = target_q;
    assign bus.br_err    = err_q;

`ifdef BR_STAT_EN
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] total_cnt_q;

    // Saturating resolved/taken branch statistics, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q <= '0;
            total_cnt_q <= '0;
        end else if (state_q == DONE) begin
            if (total_cnt_q != '1) begin
                total_cnt_q <= total_cnt_q + CNT_W'(1);
            end
            if (ben_q && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.br_taken_cnt = taken_cnt_q;
    assign bus.br_total_cnt = total_cnt_q;
`else
    assign bus.br_taken_cnt = CNT_W'(0);
    assign bus.br_total_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_data_matrix_ben_branch.sv
// Scoreboard bench for data_matrix_ben_branch: driver pushes expected results,
// a negedge monitor pops and compares when br_done / br_err appear.
module tb_data_matrix_ben_branch;
    logic clk;
    logic rst;

    data_matrix_ben_branch_if #(.AW(16)) bus ();

    data_matrix_ben_branch #(.AW(16), .OFF_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        ben;
        logic [15:0] tgt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_start = 0;
    bit active   = 0;
    bit mon_en   = 0;
    int tot_n    = 0;
    int tak_n    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: BR is opcode 0; taken when any requested flag is set
    function automatic logic model_ben(input logic [15:0] ir_v, input logic [2:0] fl);
        return (ir_v[15:12] == 4'd0) && ((ir_v[11:9] & fl) != 3'b000);
    endfunction

    function automatic logic [15:0] model_tgt(input logic [15:0] ir_v, input logic [15:0] pc_v);
        int off;
        off = int'(ir_v[8:0]);
        if (off >= 256) off = off - 512;
        return 16'(int'(pc_v) + off);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One branch starting in the current cycle; junk_k in 1..3 adds a busy-time start
    task automatic run_br(input logic [15:0] ir_v, input logic [15:0] pc_v,
                          input logic [2:0] fl, input int junk_k);
        exp_t e;
        int   c0;
        c0 = cyc;
        bus.br_start = 1'b1;
        bus.ir = ir_v;
        bus.pc = pc_v;
        {bus.reg_n, bus.reg_z, bus.reg_p} = fl;
        e.ben = model_ben(ir_v, fl);
        e.tgt = model_tgt(ir_v, pc_v);
        e.cyc = c0 + 3;
        exp_q.push_back(e);
        if (ir_v[15:12] != 4'd0) err_q.push_back(c0 + 1);
        if (tot_n < 16'hFFFF) tot_n++;
        if (e.ben && tak_n < 16'hFFFF) tak_n++;
        last_start = c0;
        active = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            bus.br_start = (k == junk_k);
            if (k == junk_k) begin
                bus.ir = 16'($urandom);
                bus.pc = 16'($urandom);
                err_q.push_back(c0 + k + 1);
            end
            if (k == 2) {bus.reg_n, bus.reg_z, bus.reg_p} = 3'($urandom);
        end
        tick();
        bus.br_start = 1'b0;
    endtask

    task automatic chk_counters(input string tag);
`ifdef BR_STAT_EN
        chk({tag, "_total_cnt"}, 32'(bus.br_total_cnt), 32'(tot_n));
        chk({tag, "_taken_cnt"}, 32'(bus.br_taken_cnt), 32'(tak_n));
`else
        chk({tag, "_total_cnt"}, 32'(bus.br_total_cnt), 32'h0);
        chk({tag, "_taken_cnt"}, 32'(bus.br_taken_cnt), 32'h0);
`endif
    endtask

    // Monitor: busy window, error pulses and completion results
    always @(negedge clk) begin
        if (mon_en) begin
            chk("br_busy", 32'(bus.br_busy),
                32'(active && (cyc > last_start) && (cyc <= last_start + 3)));
            if (bus.br_err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_br_err", 32'(1), 32'(0));
                end else begin
                    chk("br_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
                end
            end
            if (bus.br_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_br_done", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.cyc));
                    chk("ben", 32'(bus.ben), 32'(e.ben));
                    chk("ld_pc", 32'(bus.ld_pc), 32'(e.ben));
                    chk("pc_target", 32'(bus.pc_target), 32'(e.tgt));
                end
            end else if (bus.ld_pc) begin
                chk("ld_pc_without_done", 32'(1), 32'(0));
            end
        end
    end

    initial begin
        logic [15:0] ir_r;
        int          c0;
        rst = 1'b1;
        bus.br_start = 1'b0;
        bus.ir = '0;
        bus.pc = '0;
        bus.reg_n = 1'b0;
        bus.reg_z = 1'b0;
        bus.reg_p = 1'b0;

        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", 32'(bus.br_busy), 32'h0);
        chk("rst_done", 32'(bus.br_done), 32'h0);
        chk("rst_ben", 32'(bus.ben), 32'h0);
        chk("rst_ld_pc", 32'(bus.ld_pc), 32'h0);
        chk("rst_err", 32'(bus.br_err), 32'h0);
        chk("rst_target", 32'(bus.pc_target), 32'h0);
        chk("rst_total_cnt", 32'(bus.br_total_cnt), 32'h0);
        chk("rst_taken_cnt", 32'(bus.br_taken_cnt), 32'h0);

        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (5) tick();

        // Directed vectors
        run_br(16'h0802, 16'h3001, 3'b100, 0);
        run_br(16'h0BFE, 16'h3001, 3'b010, 0);
        run_br(16'h0FFF, 16'h0000, 3'b100, 0);
        run_br(16'h01FF, 16'hFFFF, 3'b111, 0);
        run_br(16'h0E05, 16'h1000, 3'b001, 1);
        run_br(16'h5E05, 16'h1000, 3'b111, 3);
        tick();
        chk_counters("directed");

        // Randomized branches, busy restarts and non-BR opcodes
        for (int i = 0; i < 150; i++) begin
            ir_r = 16'($urandom);
            if ($urandom_range(0, 4) != 0) ir_r[15:12] = 4'd0;
            run_br(ir_r, 16'($urandom), 3'($urandom), int'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 2)) tick();
        end
        tick();
        chk_counters("random");

        // Busy restart then reset mid-flight: error pulse only, no completion
        c0 = cyc;
        bus.br_start = 1'b1;
        bus.ir = 16'h0FFF;
        bus.pc = 16'h1234;
        {bus.reg_n, bus.reg_z, bus.reg_p} = 3'b111;
        last_start = c0;
        active = 1'b1;
        err_q.push_back(c0 + 2);
        tick();
        bus.ir = 16'h0E01;
        tick();
        bus.br_start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        active = 1'b0;
        tot_n = 0;
        tak_n = 0;
        repeat (6) tick();
        chk("abort_ld_pc", 32'(bus.ld_pc), 32'h0);
        chk_counters("after_abort");

        // Three branches, two taken
        run_br(16'h0802, 16'h3001, 3'b100, 0);
        run_br(16'h0FFF, 16'h0000, 3'b100, 0);
        run_br(16'h01FF, 16'hFFFF, 3'b111, 0);
        tick();
        chk_counters("three_br");

        repeat (3) tick();
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("err_q_drained", 32'(err_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
